// File: rtl/cpu_joypad_port.sv
// cpu_joypad_port: CPU-bus responder for the two controller ports ($4016/$4017).
// A write to port 1 latches the controller strobe from D_in[0]. While strobe is
// high, both 8-bit shift registers reload from the live button inputs every cycle.
// While strobe is low, each read shifts one button bit out, LSB first, and shifts
// a 1 in at the top.
//
// Ports:
//   Clk, reset          clock, asynchronous active-low reset
//   addr, write, bus_en CPU access; the access is taken only in bus_en cycles
//   D_in                CPU write data (only bit 0 is used, by port 1)
//   pad1/2_buttons      live controller buttons, active-high, bit0 = A
//   D_out, rd_valid     registered read data and a one-cycle valid pulse
//   strobe              current strobe latch
//   pad1/2_count        reads since the last reload, saturating at 8
module cpu_joypad_port #(
  parameter logic [15:0] BASE_ADDR = 16'h4016,
  parameter logic [7:0]  OPEN_BUS  = 8'h40
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        write,
  input  logic        bus_en,
  input  logic [7:0]  D_in,
  input  logic [7:0]  pad1_buttons,
  input  logic [7:0]  pad2_buttons,
  output logic [7:0]  D_out,
  output logic        rd_valid,
  output logic        strobe,
  output logic [3:0]  pad1_count,
  output logic [3:0]  pad2_count
);

  localparam int unsigned SR_W  = 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SR_W);
  localparam logic [15:0] PORT2_ADDR = 16'(BASE_ADDR + 16'd1);

  typedef enum logic [1:0] {
    LOADING   = 2'd0,
    SHIFTING  = 2'd1,
    EXHAUSTED = 2'd2
  } port_state_e;

  // Port state is fully determined by the strobe latch and the read count.
  function automatic port_state_e port_state(input logic stb, input logic [CNT_W-1:0] cnt);
    if (stb)                 return LOADING;
    else if (cnt < CNT_MAX)  return SHIFTING;
    else                     return EXHAUSTED;
  endfunction

  logic [SR_W-1:0]  sr1, sr2;
  logic [SR_W-1:0]  sr1_nxt, sr2_nxt;
  logic [CNT_W-1:0] cnt1_nxt, cnt2_nxt;
  logic [7:0]       d_out_nxt;
  logic             rd_valid_nxt;
  logic             strobe_nxt;

  logic        hit1_c, hit2_c, rd1_c, rd2_c;
  port_state_e state1_c, state2_c;

  // Bits 7:1 of write data have no function in this block.
  logic d_in_unused_c;
  assign d_in_unused_c = ^D_in[7:1];

  assign hit1_c   = bus_en && (addr == BASE_ADDR);
  assign hit2_c   = bus_en && (addr == PORT2_ADDR);
  assign rd1_c    = hit1_c && !write;
  assign rd2_c    = hit2_c && !write;
  assign state1_c = port_state(strobe, pad1_count);
  assign state2_c = port_state(strobe, pad2_count);

  // State register.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      strobe     <= 1'b0;
      sr1        <= '1;
      sr2        <= '1;
      pad1_count <= '0;
      pad2_count <= '0;
      D_out      <= 8'h00;
      rd_valid   <= 1'b0;
    end else begin
      strobe     <= strobe_nxt;
      sr1        <= sr1_nxt;
      sr2        <= sr2_nxt;
      pad1_count <= cnt1_nxt;
      pad2_count <= cnt2_nxt;
      D_out      <= d_out_nxt;
      rd_valid   <= rd_valid_nxt;
    end
  end

  // Next-state and read-data logic.
  always_comb begin
    strobe_nxt   = strobe;
    sr1_nxt      = sr1;
    sr2_nxt      = sr2;
    cnt1_nxt     = pad1_count;
    cnt2_nxt     = pad2_count;
    d_out_nxt    = D_out;
    rd_valid_nxt = 1'b0;

    // Port-2 writes go to the APU frame counter and are ignored here.
    if (hit1_c && write) strobe_nxt = D_in[0];

    // Reload decisions use the strobe value from before this edge.
    case (state1_c)
      LOADING: begin
        sr1_nxt  = pad1_buttons;
        cnt1_nxt = '0;
      end
      SHIFTING: begin
        if (rd1_c) begin
          sr1_nxt  = {1'b1, sr1[SR_W-1:1]};
          cnt1_nxt = pad1_count + CNT_W'(1);
        end
      end
      EXHAUSTED: begin
        if (rd1_c) sr1_nxt = {1'b1, sr1[SR_W-1:1]};
      end
      default: ;
    endcase

    case (state2_c)
      LOADING: begin
        sr2_nxt  = pad2_buttons;
        cnt2_nxt = '0;
      end
      SHIFTING: begin
        if (rd2_c) begin
          sr2_nxt  = {1'b1, sr2[SR_W-1:1]};
          cnt2_nxt = pad2_count + CNT_W'(1);
        end
      end
      EXHAUSTED: begin
        if (rd2_c) sr2_nxt = {1'b1, sr2[SR_W-1:1]};
      end
      default: ;
    endcase

    // While strobed, reads see the live A button rather than the register.
    if (rd1_c) begin
      d_out_nxt    = {OPEN_BUS[7:1], strobe ? pad1_buttons[0] : sr1[0]};
      rd_valid_nxt = 1'b1;
    end else if (rd2_c) begin
      d_out_nxt    = {OPEN_BUS[7:1], strobe ? pad2_buttons[0] : sr2[0]};
      rd_valid_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_joypad_port.sv
`timescale 1ns/1ps
// Bench for cpu_joypad_port: read results are queued when a read is issued and
// compared, together with their one-cycle latency, when rd_valid appears.
module tb_cpu_joypad_port;

  logic        Clk;
  logic        reset;
  logic [15:0] addr;
  logic        write;
  logic        bus_en;
  logic [7:0]  D_in;
  logic [7:0]  pad1_buttons;
  logic [7:0]  pad2_buttons;
  logic [7:0]  D_out;
  logic        rd_valid;
  logic        strobe;
  logic [3:0]  pad1_count;
  logic [3:0]  pad2_count;

  cpu_joypad_port dut (
    .Clk          (Clk),
    .reset        (reset),
    .addr         (addr),
    .write        (write),
    .bus_en       (bus_en),
    .D_in         (D_in),
    .pad1_buttons (pad1_buttons),
    .pad2_buttons (pad2_buttons),
    .D_out        (D_out),
    .rd_valid     (rd_valid),
    .strobe       (strobe),
    .pad1_count   (pad1_count),
    .pad2_count   (pad2_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0]  data;
    int unsigned stamp;
  } sb_entry_t;

  sb_entry_t   sb[$];
  int unsigned cyc;
  int          n_checks;
  int          n_fail;

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Read-result monitor: every rd_valid pulse must match the oldest queued read.
  always @(negedge Clk) begin
    if (reset && rd_valid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_rd_valid", 16'(rd_valid), 16'd0);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        check_eq("read_data", 16'(D_out), 16'(e.data));
        check_eq("read_latency", 16'(cyc - e.stamp), 16'd1);
      end
    end
  end

  task automatic bus_op(input logic [15:0] a, input logic w, input logic [7:0] d);
    @(negedge Clk);
    addr   = a;
    write  = w;
    D_in   = d;
    bus_en = 1'b1;
    @(posedge Clk);
    #1;
    bus_en = 1'b0;
    write  = 1'b0;
  endtask

  task automatic rd_port(input logic [15:0] a, input logic [7:0] exp);
    sb_entry_t e;
    @(negedge Clk);
    addr   = a;
    write  = 1'b0;
    bus_en = 1'b1;
    e.data  = exp;
    e.stamp = cyc;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    bus_en = 1'b0;
  endtask

  logic [7:0] exp_a5 [10] = '{8'h41, 8'h40, 8'h41, 8'h40, 8'h40,
                              8'h41, 8'h40, 8'h41, 8'h41, 8'h41};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    addr         = 16'h0000;
    write        = 1'b0;
    bus_en       = 1'b0;
    D_in         = 8'h00;
    pad1_buttons = 8'h00;
    pad2_buttons = 8'h00;

    // Reset state
    #23;
    check_eq("rst_d_out", 16'(D_out), 16'h00);
    check_eq("rst_rd_valid", 16'(rd_valid), 16'd0);
    check_eq("rst_strobe", 16'(strobe), 16'd0);
    check_eq("rst_cnt1", 16'(pad1_count), 16'd0);
    check_eq("rst_cnt2", 16'(pad2_count), 16'd0);
    @(negedge Clk);
    reset = 1'b1;

    // First read after reset shifts out the reset value of all ones
    rd_port(16'h4016, 8'h41);
    @(negedge Clk);
    check_eq("t1_cnt1", 16'(pad1_count), 16'd1);

    // Full serial readout of 8'b1010_0101, then ones past the end
    pad1_buttons = 8'hA5;
    bus_op(16'h4016, 1'b1, 8'h01);
    bus_op(16'h4016, 1'b1, 8'h00);
    @(negedge Clk);
    check_eq("t2_strobe_clr", 16'(strobe), 16'd0);
    check_eq("t2_cnt1_reload", 16'(pad1_count), 16'd0);
    for (int i = 0; i < 10; i++) begin
      rd_port(16'h4016, exp_a5[i]);
      if (i == 4) begin
        // Button changes while shifting must not disturb the register
        pad1_buttons = 8'h5A;
        @(negedge Clk);
        check_eq("t2_cnt1_mid", 16'(pad1_count), 16'd5);
      end
      if (i == 7) begin
        @(negedge Clk);
        check_eq("t2_cnt1_full", 16'(pad1_count), 16'd8);
      end
    end
    @(negedge Clk);
    check_eq("t2_cnt1_sat", 16'(pad1_count), 16'd8);

    // Strobe held high: each read returns the live A bit, no counting
    bus_op(16'h4016, 1'b1, 8'h01);
    pad1_buttons = 8'h01;
    rd_port(16'h4016, 8'h41);
    pad1_buttons = 8'hFE;
    rd_port(16'h4016, 8'h40);
    bus_op(16'h4016, 1'b1, 8'h03);
    pad1_buttons = 8'hFF;
    rd_port(16'h4016, 8'h41);
    @(negedge Clk);
    check_eq("t3_strobe_held", 16'(strobe), 16'd1);
    check_eq("t3_cnt1", 16'(pad1_count), 16'd0);

    // Independent ports, interleaved back-to-back reads
    pad1_buttons = 8'h01;
    pad2_buttons = 8'h80;
    bus_op(16'h4016, 1'b1, 8'h01);
    bus_op(16'h4016, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      rd_port(16'h4017, (i == 7) ? 8'h41 : 8'h40);
      rd_port(16'h4016, (i == 0) ? 8'h41 : 8'h40);
      if (i == 2) begin
        pad2_buttons = 8'h7F;
        @(negedge Clk);
        check_eq("t4_cnt1_mid", 16'(pad1_count), 16'd3);
        check_eq("t4_cnt2_mid", 16'(pad2_count), 16'd3);
      end
    end
    @(negedge Clk);
    check_eq("t4_cnt1", 16'(pad1_count), 16'd8);
    check_eq("t4_cnt2", 16'(pad2_count), 16'd8);

    // Non-decoded accesses and port-2 writes change nothing
    bus_op(16'h4017, 1'b1, 8'hFF);
    bus_op(16'h4018, 1'b0, 8'h00);
    bus_op(16'h4018, 1'b1, 8'h01);
    bus_op(16'h4016, 1'b1, 8'hFE);
    @(negedge Clk);
    check_eq("t5_strobe", 16'(strobe), 16'd0);
    check_eq("t5_cnt1", 16'(pad1_count), 16'd8);
    check_eq("t5_cnt2", 16'(pad2_count), 16'd8);
    check_eq("t5_d_out_hold", 16'(D_out), 16'h40);
    rd_port(16'h4017, 8'h41);
    rd_port(16'h4016, 8'h41);

    // Asynchronous reset in the middle of a readout
    pad1_buttons = 8'h00;
    bus_op(16'h4016, 1'b1, 8'h01);
    bus_op(16'h4016, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) rd_port(16'h4016, 8'h40);
    @(negedge Clk);
    check_eq("t6_cnt1_pre", 16'(pad1_count), 16'd3);
    @(negedge Clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_cnt1_rst", 16'(pad1_count), 16'd0);
    check_eq("t6_d_out_rst", 16'(D_out), 16'h00);
    check_eq("t6_strobe_rst", 16'(strobe), 16'd0);
    @(negedge Clk);
    reset = 1'b1;
    rd_port(16'h4016, 8'h41);
    rd_port(16'h4017, 8'h41);
    @(negedge Clk);
    check_eq("t6_cnt1_post", 16'(pad1_count), 16'd1);
    check_eq("t6_cnt2_post", 16'(pad2_count), 16'd1);

    // Every issued read must have produced exactly one result
    repeat (4) @(negedge Clk);
    check_eq("sb_drained", 16'(sb.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
